// File: rtl/mem_arbiter_if.sv
// Bundle between the core's fetch/load-store ports, the shared BRAM and the arbiter.
// The slave modport is the arbiter; the master modport is the core/BRAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall;
  logic              trap_ram;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall, trap_ram
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall, trap_ram
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter between instruction fetch and load/store, with store byte
// enables, alignment/range trapping and one-cycle read response routing.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {READY, TRAP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             trap_q;

  logic       if_win, d_win, illegal;
  logic [1:0] size;
  logic [3:0] be;
  logic       unused_bits;

  assign unused_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0], bus.d_func3[2]};

  always_comb begin
    size    = bus.d_func3[1:0];
    illegal = (size == 2'b11)
           || (size == 2'b01 && bus.d_addr[0])
           || (size == 2'b10 && bus.d_addr[1:0] != 2'b00)
           || (bus.d_addr[31:ADDR_W+2] != '0);

    // Starved fetch preempts data; TRAP blocks data but lets fetch through.
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst_n) begin
      if (bus.if_req && starve_cnt == STARVE_LIM)   if_win = 1'b1;
      else if (bus.d_req && state == READY)         d_win  = 1'b1;
      else if (bus.if_req)                          if_win = 1'b1;
    end

    case (size)
      2'b00:   be = 4'b0001 << bus.d_addr[1:0];
      2'b01:   be = 4'b0011 << {bus.d_addr[1], 1'b0};
      default: be = 4'b1111;
    endcase

    case (size)
      2'b00:   bus.mem_wdata = {4{bus.d_wdata[7:0]}};
      2'b01:   bus.mem_wdata = {2{bus.d_wdata[15:0]}};
      default: bus.mem_wdata = bus.d_wdata;
    endcase

    bus.if_gnt   = if_win;
    bus.d_gnt    = d_win;
    bus.mem_en   = if_win | (d_win & ~illegal);
    bus.mem_we   = (d_win && !illegal && bus.d_we) ? be : '0;
    if (if_win)     bus.mem_addr = bus.if_addr[ADDR_W+1:2];
    else if (d_win) bus.mem_addr = bus.d_addr[ADDR_W+1:2];
    else            bus.mem_addr = '0;
    bus.stall = rst_n & ((bus.if_req & ~if_win) | (bus.d_req & ~d_win));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= READY;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      trap_q     <= 1'b0;
    end else begin
      if (bus.if_req && !if_win)
        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;

      if (if_win)                               owner <= OWN_IF;
      else if (d_win && !illegal && !bus.d_we)  owner <= OWN_D;
      else                                      owner <= OWN_NONE;

      trap_q <= d_win & illegal;

      case (state)
        READY:   if (d_win && illegal) state <= TRAP;
        TRAP:    state <= READY;
        default: state <= READY;
      endcase
    end
  end

  assign bus.trap_ram  = trap_q;
  assign bus.if_rvalid = (owner == OWN_IF);
  assign bus.d_rvalid  = (owner == OWN_D);
  assign bus.if_rdata  = (owner == OWN_IF) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (owner == OWN_D)  ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level reference model
// with its own shadow copy of the BRAM contents.
module tb_mem_arbiter;
  localparam int AW     = 10;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) ifc();
  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(STARVE)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [31:0] bram    [1<<AW];
  logic [31:0] ref_mem [1<<AW];

  always @(posedge clk) begin
    if (ifc.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (ifc.mem_we[b]) bram[ifc.mem_addr][8*b +: 8] <= ifc.mem_wdata[8*b +: 8];
      ifc.mem_rdata <= bram[ifc.mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_if_rv, m_d_rv, m_trap;
  logic [31:0] m_if_data, m_d_data;
  int          m_starve;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if_rv = 1'b0; m_d_rv = 1'b0; m_trap = 1'b0;
    m_if_data = '0; m_d_data = '0; m_starve = 0;
  endtask

  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                       input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd);
    logic        ill, fw, dw, st;
    int          size, off;
    logic [3:0]  ewe;
    logic [31:0] ewd;
    @(negedge clk);
    ifc.if_req = ir; ifc.if_addr = ia; ifc.d_req = dr; ifc.d_we = we;
    ifc.d_func3 = f3; ifc.d_addr = da; ifc.d_wdata = wd;
    #1;
    check("if_rvalid", ifc.if_rvalid, m_if_rv);
    check("if_rdata",  ifc.if_rdata,  m_if_rv ? m_if_data : 32'h0);
    check("d_rvalid",  ifc.d_rvalid,  m_d_rv);
    check("d_rdata",   ifc.d_rdata,   m_d_rv ? m_d_data : 32'h0);
    check("trap_ram",  ifc.trap_ram,  m_trap);

    ill = (f3[1:0] == 2'b11) || (f3[1:0] == 2'b01 && da[0])
       || (f3[1:0] == 2'b10 && da[1:0] != 2'b00) || ((da >> (AW + 2)) != 0);
    fw  = ir && (m_starve == STARVE || !(dr && !m_trap));
    dw  = dr && !m_trap && !fw;
    st  = dw && !ill && we;
    size = 1 << f3[1:0];
    off  = int'(da[1:0]);
    for (int b = 0; b < 4; b++) begin
      ewe[b]        = st && (b >= off) && (b < off + size);
      ewd[8*b +: 8] = wd[8*(b % size) +: 8];
    end

    check("if_gnt", ifc.if_gnt, fw);
    check("d_gnt",  ifc.d_gnt,  dw);
    check("mem_en", ifc.mem_en, fw || (dw && !ill));
    check("mem_we", ifc.mem_we, ewe);
    check("stall",  ifc.stall,  (ir && !fw) || (dr && !dw));
    if (fw)               check("mem_addr_if", ifc.mem_addr, ia[AW+1:2]);
    else if (dw && !ill)  check("mem_addr_d",  ifc.mem_addr, da[AW+1:2]);
    if (st)               check("mem_wdata",   ifc.mem_wdata, ewd);

    m_if_rv   = fw;
    m_if_data = ref_mem[ia[AW+1:2]];
    m_d_rv    = dw && !ill && !we;
    m_d_data  = ref_mem[da[AW+1:2]];
    for (int b = 0; b < 4; b++)
      if (ewe[b]) ref_mem[da[AW+1:2]][8*b +: 8] = ewd[8*b +: 8];
    m_trap   = dw && ill;
    m_starve = (ir && !fw) ? ((m_starve + 1 > STARVE) ? STARVE : m_starve + 1) : 0;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_gnt"},  ifc.if_gnt,    1'b0);
    check({tag, "_d_gnt"},   ifc.d_gnt,     1'b0);
    check({tag, "_mem_en"},  ifc.mem_en,    1'b0);
    check({tag, "_mem_we"},  ifc.mem_we,    4'h0);
    check({tag, "_stall"},   ifc.stall,     1'b0);
    check({tag, "_if_rv"},   ifc.if_rvalid, 1'b0);
    check({tag, "_d_rv"},    ifc.d_rvalid,  1'b0);
    check({tag, "_trap"},    ifc.trap_ram,  1'b0);
    check({tag, "_if_rd"},   ifc.if_rdata,  32'h0);
    check({tag, "_d_rd"},    ifc.d_rdata,   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ir, dr, we;
    logic [2:0]  f3;
    logic [31:0] ia, da, wd;
    int          r;

    for (int i = 0; i < (1 << AW); i++) begin
      bram[i]    = 32'(i) * 32'h01010101 ^ 32'hA5C3_0000;
      ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5C3_0000;
    end
    bram[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;

    rst_n = 1'b0;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h0; ifc.d_req = 1'b1; ifc.d_we = 1'b0;
    ifc.d_func3 = 3'b010; ifc.d_addr = 32'h0; ifc.d_wdata = 32'h0;
    model_reset();
    #2;
    check_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; ifc.if_req = 1'b0; ifc.d_req = 1'b0;

    // fetch only
    cycle(1'b1, 32'h0C, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("fetch_gnt", ifc.if_gnt, 1'b1);
    check("fetch_stall", ifc.stall, 1'b0);
    idle();
    check("fetch_rdata", ifc.if_rdata, 32'hDEADBEEF);

    // byte/half/word stores then load-back
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h11, 32'h0000_00AB);
    check("sb_we", ifc.mem_we, 4'b0010);
    check("sb_wdata", ifc.mem_wdata, 32'hABABABAB);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 3'b001, 32'h12, 32'h0000_1234);
    check("sh_we", ifc.mem_we, 4'b1100);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h55AA55AA);
    check("sw_we", ifc.mem_we, 4'b1111);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    idle();
    check("lw_back", ifc.d_rdata, 32'h55AA55AA);

    // contention: starvation forces fetch on the fifth cycle
    idle();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 32'h40, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
      check("cont_d_gnt",  ifc.d_gnt,  (k != 4));
      check("cont_if_gnt", ifc.if_gnt, (k == 4));
      check("cont_stall",  ifc.stall,  1'b1);
    end
    idle();

    // illegal accesses, plus a data request during the trap cycle
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
    check("ill_mis_gnt", ifc.d_gnt, 1'b1);
    check("ill_mis_en",  ifc.mem_en, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
    check("trap_pulse",  ifc.trap_ram, 1'b1);
    check("trap_no_dgnt", ifc.d_gnt, 1'b0);
    idle(); idle();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
    check("ill_f3_en", ifc.mem_en, 1'b0);
    idle();
    check("ill_f3_trap", ifc.trap_ram, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
    check("ill_rng_en", ifc.mem_en, 1'b0);
    idle();
    check("ill_rng_trap", ifc.trap_ram, 1'b1);
    idle();

    // reset while a load response is pending
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    #1;
    rst_n = 1'b0; ifc.if_req = 1'b1; ifc.d_req = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    @(posedge clk); #1;
    check_reset_outputs("rstmid_edge");
    @(negedge clk);
    rst_n = 1'b1; ifc.if_req = 1'b0; ifc.d_req = 1'b0;
    model_reset();

    // store followed immediately by load of the same word
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    idle();
    check("fwd_rdata", ifc.d_rdata, 32'h1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 15));
      if (r < 4)       f3 = 3'b000;
      else if (r < 8)  f3 = 3'b001;
      else if (r < 14) f3 = 3'b010;
      else             f3 = 3'($urandom);
      da = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) da = da | (32'h1 << $urandom_range(12, 31));
      ia = $urandom;
      wd = $urandom;
      cycle(ir, ia, dr, we, f3, da, wd);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port synchronous BRAM between the core's instruction-fetch port and its load/store port. Converts `func3` store widths into byte enables, checks alignment and range, and routes one-cycle-latency read data back to the requester that issued the access. Sits between the core pipeline and the shared program/data BRAM. Drives the core's `stall` and `trap_ram` inputs.

## Interface
- `ADDR_W`, 10: BRAM word-index width; depth is 2^ADDR_W words.
- `STARVE_MAX`, 4: consecutive denied fetch cycles before fetch is forced to win.

Clocking: one clock; reset is asynchronous and active-low.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  32  fetch byte address (pc)
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  `if_rdata` valid
- `if_rdata`  out  32  instruction word
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_func3`  in  3  access width: 000 byte, 001 half, 010 word
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data, LSB-justified
- `d_gnt`  out  1  data accepted this cycle
- `d_rvalid`  out  1  `d_rdata` valid (loads only)
- `d_rdata`  out  32  raw aligned word; the core performs extraction and sign extension
- `mem_en`  out  1  BRAM enable
- `mem_we`  out  4  BRAM byte write enables
- `mem_addr`  out  ADDR_W  BRAM word index
- `mem_wdata`  out  32  BRAM write data
- `mem_rdata`  in  32  BRAM read data, valid one cycle after `mem_en`
- `stall`  out  1  a request is pending but not granted
- `trap_ram`  out  1  one-cycle pulse on an illegal data access

## Operation

**Arbitration**
- Combinational within each cycle.
- Data wins by default.
- Fetch wins when `starve_cnt == STARVE_MAX`.
- At most one grant per cycle.
- A grant drives `mem_en = 1`, `mem_addr = addr[ADDR_W+1:2]`, and the byte enables.

**Starvation counter (`starve_cnt`)**
- Increments (saturating at `STARVE_MAX`) on any cycle with `if_req && !if_gnt`.
- Clears on `if_gnt` or `!if_req`.

**Byte enables (stores)**
- Byte: `mem_we = 4'b0001 << d_addr[1:0]`, `mem_wdata = {4{d_wdata[7:0]}}`.
- Half: `mem_we = 4'b0011 << (2*d_addr[1])`, `mem_wdata = {2{d_wdata[15:0]}}`.
- Word: `mem_we = 4'b1111`, `mem_wdata = d_wdata`.
- Loads and fetches use `mem_we = 0`.

**Illegal data access**
- Any of these is illegal:
  - `d_func3[1:0] == 11`
  - half access with `d_addr[0] == 1`
  - word access with `d_addr[1:0] != 0`
  - `d_addr[31:ADDR_W+2] != 0`
- Response: `d_gnt = 1` (the request is consumed), `mem_en = 0`, no `d_rvalid`, FSM enters TRAP.
- Fetch is never trapped. Misaligned `if_addr[1:0]` bits are ignored.

**FSM**
- READY: normal arbitration.
- TRAP: lasts one cycle.
  - `trap_ram = 1`.
  - No data grant.
  - Fetch may still be granted.
  - Returns to READY.

**Response routing**
- A register `owner ∈ {NONE, IF, D_LOAD}` captures the winner of each granted read.
- In the next cycle:
  - `owner == IF` → `if_rvalid = 1`, `if_rdata = mem_rdata`.
  - `owner == D_LOAD` → `d_rvalid = 1`, `d_rdata = mem_rdata`.
- Granted stores set `owner = NONE`.

**Stall**
- `stall = (if_req & !if_gnt) | (d_req & !d_gnt)`.

## Timing
- Reset (async assert):
  - FSM = READY, `owner = NONE`, `starve_cnt = 0`.
  - Registered outputs (`if_rvalid`, `d_rvalid`, `trap_ram`) are 0.
  - Combinational outputs evaluate with `rst_n` low as no grant: `mem_en = 0`, `mem_we = 0`, `stall = 0`.
  - `if_rdata` / `d_rdata` read 0 while their rvalid is 0.
- Grant cycle N: the BRAM samples at edge N→N+1.
- Read response: `*_rvalid` high in cycle N+1 only. Read latency is exactly 1. Back-to-back grants give one response per cycle.
- Store: the write is committed at edge N→N+1. A load to the same word granted in N+1 returns the new data.
- `trap_ram`: high in cycle N+1 after the illegal request is accepted in cycle N.
- Reset mid-access: the pending response is dropped (`owner` cleared) and no rvalid is produced after reset.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: data granted, fetch stalls.

## Test plan
- **Fetch only:** preload word 3 = 0xDEADBEEF; `if_req=1`, `if_addr=0x0C` → `if_gnt` in cycle 0, `if_rvalid=1` and `if_rdata=0xDEADBEEF` in cycle 1, `stall=0`.
- **Byte/half/word stores:**
  - SB 0xAB to 0x11 → `mem_we=0010`, `mem_wdata=0xABABABAB`.
  - SH 0x1234 to 0x12 → `mem_we=1100`.
  - SW 0x55AA55AA to 0x10 → `mem_we=1111`.
  - A subsequent LW of 0x10 returns 0x55AA55AA.
- **Contention:** `if_req` and `d_req` held high for 6 cycles (loads) → data granted in cycles 0–3, fetch granted in cycle 4 (`starve_cnt` reached 4), data in cycle 5; `stall=1` every cycle.
- **Misaligned/illegal:** LW at 0x02 → `d_gnt=1`, `mem_en=0`, `trap_ram=1` in the next cycle, no `d_rvalid`; repeat with `func3=011` and with `d_addr=0x1000` (ADDR_W=10) → same result.
- **Reset mid-access:** grant a load, assert `rst_n=0` before the next edge → `d_rvalid` stays 0; all outputs at reset values while `rst_n` is low.
- **Store→load forwarding through BRAM:** SW 0x1 to 0x20 in cycle 0, LW 0x20 in cycle 1 → `d_rdata=0x00000001` in cycle 2.
